// File: rtl/sipo8_collector_pkg.sv
// Shared definitions for the serial-to-parallel collector and the AND stage it feeds.
package sipo8_collector_pkg;

  // Width of an assembled word and of the bit counter that indexes into it.
  localparam int WORD_W = 8;
  localparam int CNT_W  = 3;

  // Collector states: nothing held, partial word held, complete word held.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Map the arrival index of a bit to its slot in the word.
  function automatic logic [CNT_W-1:0] bit_slot(input logic [CNT_W-1:0] idx,
                                                input logic             msb_first);
    logic [CNT_W-1:0] top_slot;
    top_slot = CNT_W'(WORD_W - 1);
    return msb_first ? (top_slot - idx) : idx;
  endfunction

endpackage

// File: rtl/sipo8_collector_counter.sv
// Modulo-8 counter that tracks how many bits of the current word have arrived.
module mod8_counter
  import sipo8_collector_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment, increment wraps naturally at 8.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Wrap flags the increment that completes a word (7 -> 0).
  always_comb begin
    wrap = inc && !clr && (count_q == '1);
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sipo8_collector.sv
// Collects eight serial bits into a word and holds it until the consumer takes it.
module sipo8_collector
  import sipo8_collector_pkg::*;
#(
  parameter int unsigned MSB_FIRST = 0
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  bit_count
);

  localparam logic MSB_SEL = (MSB_FIRST != 0);

  state_e            state_q;
  state_e            state_d;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;
  logic              bit_xfer;
  logic              word_xfer;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_wrap;

  // Handshake outputs decode registered state only, so there is no input-to-output path.
  always_comb begin
    bit_ready  = (state_q != HOLD);
    word_valid = (state_q == HOLD);
  end

  // Transfer qualifiers; a bit arriving alongside clear is dropped.
  always_comb begin
    bit_xfer  = bit_valid && bit_ready && !clear;
    word_xfer = word_valid && word_ready;
  end

  mod8_counter u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bit_xfer),
    .clr   (clear),
    .count (cnt),
    .wrap  (cnt_wrap)
  );

  // Shift register: only an accepted bit writes its slot; everything else holds.
  always_comb begin
    word_d = word_q;
    if (bit_xfer) begin
      word_d[bit_slot(cnt, MSB_SEL)] = bit_in;
    end
  end

  // Next-state logic; clear aborts from any state without zeroing the word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bit_xfer) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_wrap) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (word_xfer) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear) begin
      state_d = IDLE;
    end
  end

  // State and word registers; reset overrides clear and every transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  assign word_out  = word_q;
  assign bit_count = cnt;

endmodule

// File: tb/tb_sipo8_collector.sv
// Directed bench for sipo8_collector, run on an LSB-first and an MSB-first instance in parallel.
module tb_sipo8_collector;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       bit_in;
  logic       bit_valid;
  logic       word_ready;

  logic       lsb_bit_ready;
  logic [7:0] lsb_word_out;
  logic       lsb_word_valid;
  logic [2:0] lsb_bit_count;
  logic       msb_bit_ready;
  logic [7:0] msb_word_out;
  logic       msb_word_valid;
  logic [2:0] msb_bit_count;

  int checks;
  int failures;

  sipo8_collector #(.MSB_FIRST(0)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (lsb_bit_ready),
    .word_out   (lsb_word_out),
    .word_valid (lsb_word_valid),
    .word_ready (word_ready),
    .bit_count  (lsb_bit_count)
  );

  sipo8_collector #(.MSB_FIRST(1)) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (msb_bit_ready),
    .word_out   (msb_word_out),
    .word_valid (msb_word_valid),
    .word_ready (word_ready),
    .bit_count  (msb_bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one bit, waiting (bounded) for the collector to be ready first.
  task automatic applyStimulus(input logic b);
    int guard;
    guard = 0;
    bit_valid = 1'b0;
    while (!lsb_bit_ready && guard < 20) begin
      cycle();
      guard++;
    end
    if (guard >= 20) begin
      failures++;
      $display("[TB] FAIL ready_timeout: bit_ready=%0b required 1 within 20 cycles", lsb_bit_ready);
    end
    bit_in    = b;
    bit_valid = 1'b1;
    cycle();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (lsb_word_valid !== 1'b0 || msb_word_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_valid: got %0b/%0b required 0", lsb_word_valid, msb_word_valid);
      end
      checks++;
      if (lsb_word_out !== 8'h00 || msb_word_out !== 8'h00 || lsb_bit_count !== 3'd0) begin
        failures++;
        $display("[TB] FAIL reset_word: got %h/%h cnt %0d required 00/00 cnt 0",
                 lsb_word_out, msb_word_out, lsb_bit_count);
      end
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if (lsb_bit_ready !== 1'b1 || msb_bit_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %0b/%0b required 1", lsb_bit_ready, msb_bit_ready);
    end
  endtask

  task automatic test_word_order();
    logic [7:0] stream;
    logic [7:0] held_lsb;
    stream = 8'b1000_1101;
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lsb_word_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL early_valid bit %0d: got %0b required 0", i, lsb_word_valid);
      end
      applyStimulus(stream[i]);
    end
    checks++;
    if (lsb_word_valid !== 1'b1 || msb_word_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL word_valid_latency: got %0b/%0b required 1", lsb_word_valid, msb_word_valid);
    end
    checks++;
    if (lsb_word_out !== 8'h8D) begin
      failures++;
      $display("[TB] FAIL lsb_word: got %h required 8d", lsb_word_out);
    end
    checks++;
    if (msb_word_out !== 8'hB1) begin
      failures++;
      $display("[TB] FAIL msb_word: got %h required b1", msb_word_out);
    end
    held_lsb = lsb_word_out;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (lsb_bit_ready !== 1'b0 || lsb_word_out !== 8'h8D || msb_word_out !== 8'hB1 ||
          lsb_bit_count !== 3'd0) begin
        failures++;
        $display("[TB] FAIL hold_stable cycle %0d: ready %0b word %h/%h cnt %0d required 0 8d/b1 0",
                 i, lsb_bit_ready, lsb_word_out, msb_word_out, lsb_bit_count);
      end
    end
    word_ready = 1'b1;
    bit_in     = 1'b1;
    cycle();
    checks++;
    if (lsb_word_valid !== 1'b0 || lsb_bit_ready !== 1'b1 || lsb_bit_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL consume: valid %0b ready %0b cnt %0d required 0 1 0",
               lsb_word_valid, lsb_bit_ready, lsb_bit_count);
    end
    checks++;
    if (lsb_word_out !== held_lsb) begin
      failures++;
      $display("[TB] FAIL no_passthrough: word %h required %h", lsb_word_out, held_lsb);
    end
    word_ready = 1'b0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
  endtask

  task automatic test_gapped();
    int gap;
    for (int k = 0; k < 8; k++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        bit_in = 1'b0;
        cycle();
        checks++;
        if (lsb_bit_count !== 3'(k)) begin
          failures++;
          $display("[TB] FAIL gap_count: got %0d required %0d", lsb_bit_count, k);
        end
      end
      applyStimulus(1'b1);
      checks++;
      if (lsb_bit_count !== 3'(k + 1) || msb_bit_count !== 3'(k + 1)) begin
        failures++;
        $display("[TB] FAIL gapped_count: got %0d/%0d required %0d",
                 lsb_bit_count, msb_bit_count, 3'(k + 1));
      end
    end
    checks++;
    if (lsb_word_out !== 8'hFF || msb_word_out !== 8'hFF || lsb_word_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL gapped_word: got %h/%h valid %0b required ff/ff 1",
               lsb_word_out, msb_word_out, lsb_word_valid);
    end
    word_ready = 1'b1;
    cycle();
    word_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] stream;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1);
    end
    checks++;
    if (lsb_bit_count !== 3'd5) begin
      failures++;
      $display("[TB] FAIL abort_pre_count: got %0d required 5", lsb_bit_count);
    end
    clear     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    cycle();
    clear     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    checks++;
    if (lsb_bit_count !== 3'd0 || lsb_word_valid !== 1'b0 || lsb_bit_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_state: cnt %0d valid %0b ready %0b required 0 0 1",
               lsb_bit_count, lsb_word_valid, lsb_bit_ready);
    end
    stream = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(stream[i]);
    end
    checks++;
    if (lsb_word_out !== 8'h3C || msb_word_out !== 8'h3C || lsb_word_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_next_word: got %h/%h valid %0b required 3c/3c 1",
               lsb_word_out, msb_word_out, lsb_word_valid);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if (lsb_word_valid !== 1'b0 || msb_word_valid !== 1'b0 || lsb_bit_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clear_in_hold: valid %0b/%0b ready %0b required 0/0 1",
               lsb_word_valid, msb_word_valid, lsb_bit_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] first;
    logic [7:0] second;
    first  = 8'h0F;
    second = 8'h33;
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(first[i]);
    end
    checks++;
    if (lsb_word_out !== 8'h0F || msb_word_out !== 8'hF0 || lsb_word_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_first: got %h/%h valid %0b required 0f/f0 1",
               lsb_word_out, msb_word_out, lsb_word_valid);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(second[i]);
    end
    checks++;
    if (lsb_word_out !== 8'h33 || msb_word_out !== 8'hCC || lsb_word_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_second: got %h/%h valid %0b required 33/cc 1",
               lsb_word_out, msb_word_out, lsb_word_valid);
    end
    cycle();
    word_ready = 1'b0;
    checks++;
    if (lsb_word_valid !== 1'b0 || lsb_bit_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL b2b_drain: valid %0b cnt %0d required 0 0", lsb_word_valid, lsb_bit_count);
    end
  endtask

  task automatic test_reset_in_hold();
    logic [7:0] stream;
    stream = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(stream[i]);
    end
    checks++;
    if (lsb_word_valid !== 1'b1 || lsb_word_out !== 8'hA5 || msb_word_out !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL rst_hold_pre: valid %0b word %h/%h required 1 a5/a5",
               lsb_word_valid, lsb_word_out, msb_word_out);
    end
    rst_n      = 1'b0;
    word_ready = 1'b1;
    cycle();
    checks++;
    if (lsb_word_valid !== 1'b0 || lsb_word_out !== 8'h00 || msb_word_out !== 8'h00 ||
        lsb_bit_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL rst_hold: valid %0b word %h/%h cnt %0d required 0 00/00 0",
               lsb_word_valid, lsb_word_out, msb_word_out, lsb_bit_count);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (lsb_word_valid !== 1'b0 || msb_word_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rst_hold_after: valid %0b/%0b required 0", lsb_word_valid, msb_word_valid);
      end
    end
    word_ready = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    clear      = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    $display("[TB] starting sipo8_collector bench");
    test_reset();
    test_word_order();
    test_gapped();
    test_abort();
    test_back_to_back();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
